// File: rtl/sd_bd_dispatch_pkg.sv
// Shared SD controller definitions: BD store geometry macros, BD dispatcher
// state encoding and counter width.
`ifndef BD_WIDTH
`define BD_WIDTH 8
`endif
`ifndef RAM_MEM_WIDTH
`define RAM_MEM_WIDTH 32
`endif

package sd_defines;

  localparam int BD_NUM_DEF = 4;
  localparam int BD_W       = `BD_WIDTH;
  localparam int RAM_W      = `RAM_MEM_WIDTH;
  localparam int DONE_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD0   = 3'd1,
    RD1   = 3'd2,
    CAP   = 3'd3,
    START = 3'd4,
    WAIT  = 3'd5,
    CMPL  = 3'd6,
    HOLD  = 3'd7
  } bd_state_t;

  // A descriptor is pending whenever the store reports fewer free slots than it holds.
  function automatic logic bd_pending(input logic [BD_W-1:0] free_cnt, input int bd_num);
    return free_cnt < BD_W'(bd_num);
  endfunction

endpackage

// File: rtl/sd_bd_dispatch.sv
// BD dispatcher: fetches two-word descriptors, launches one transfer per BD and
// acknowledges completion to the BD store. Optional retry: SD_BD_DISPATCH_RETRY_EN.
module sd_bd_dispatch
  import sd_defines::*;
#(
  parameter int BD_NUM = BD_NUM_DEF,
  parameter int AW     = RAM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [`BD_WIDTH-1:0]  free_bd,
  output logic                  bd_re,
  input  logic [AW-1:0]         bd_dat,
  output logic                  a_cmp,
  output logic                  xfer_start,
  output logic [AW-1:0]         xfer_sys_addr,
  output logic [AW-1:0]         xfer_blk_addr,
  input  logic                  xfer_done,
  input  logic                  xfer_err,
  output logic                  busy,
  output logic                  err_flag,
  output logic [DONE_CNT_W-1:0] done_cnt
);

  bd_state_t             state_reg, state_next;
  logic [AW-1:0]         sys_addr_reg, blk_addr_reg;
  logic [BD_W-1:0]       free_rec_reg;
  logic [BD_W-1:0]       free_inc;
  logic                  err_flag_reg;
  logic [DONE_CNT_W-1:0] done_cnt_reg;
  logic                  err_set;
`ifdef SD_BD_DISPATCH_RETRY_EN
  logic                  retry_used_reg;
`endif

  // The store's increment for our a_cmp is what we expect to see in HOLD.
  assign free_inc = free_rec_reg + BD_W'(1);

  always_comb begin
    state_next = state_reg;
    bd_re      = 1'b0;
    a_cmp      = 1'b0;
    xfer_start = 1'b0;
    err_set    = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE:  if (en && bd_pending(free_bd, BD_NUM)) state_next = RD0;
      RD0: begin
        bd_re      = 1'b1;
        state_next = RD1;
      end
      RD1: begin
        bd_re      = 1'b1;
        state_next = CAP;
      end
      CAP:   state_next = START;
      START: begin
        xfer_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (xfer_done) begin
`ifdef SD_BD_DISPATCH_RETRY_EN
          if (xfer_err && !retry_used_reg) begin
            state_next = START;
          end else begin
            state_next = CMPL;
            err_set    = xfer_err;
          end
`else
          state_next = CMPL;
          err_set    = xfer_err;
`endif
        end
      end
      CMPL: begin
        a_cmp      = 1'b1;
        state_next = HOLD;
      end
      // Anything other than our own increment means a store decrement collided.
      HOLD:    state_next = (free_bd == free_inc) ? IDLE : CMPL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      sys_addr_reg <= '0;
      blk_addr_reg <= '0;
      free_rec_reg <= '0;
      err_flag_reg <= 1'b0;
      done_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == RD1) sys_addr_reg <= bd_dat;
      if (state_reg == CAP) blk_addr_reg <= bd_dat;
      if (state_reg == CMPL) free_rec_reg <= free_bd;
      if (err_set) err_flag_reg <= 1'b1;
      if (state_reg == HOLD && state_next == IDLE)
        done_cnt_reg <= done_cnt_reg + DONE_CNT_W'(1);
    end
  end

`ifdef SD_BD_DISPATCH_RETRY_EN
  // One relaunch per descriptor; cleared once the dispatcher is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_used_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      retry_used_reg <= 1'b0;
    end else if (state_reg == WAIT && xfer_done && xfer_err) begin
      retry_used_reg <= 1'b1;
    end
  end
`endif

  assign xfer_sys_addr = sys_addr_reg;
  assign xfer_blk_addr = blk_addr_reg;
  assign err_flag      = err_flag_reg;
  assign done_cnt      = done_cnt_reg;

endmodule

// File: tb/tb_sd_bd_dispatch.sv
// Self-checking bench for sd_bd_dispatch: BD store model, address scoreboard,
// table of descriptor transactions and hand-written corner sequences.
module tb_sd_bd_dispatch;
  import sd_defines::*;

  localparam int AW     = 32;
  localparam int BD_NUM = 4;

  logic            clk = 1'b0;
  logic            rst, en, bd_re, a_cmp, xfer_start, xfer_done, xfer_err, busy, err_flag;
  logic [BD_W-1:0] free_bd;
  logic [AW-1:0]   bd_dat, xfer_sys_addr, xfer_blk_addr;
  logic [15:0]     done_cnt;

  always #5 clk = ~clk;

  sd_bd_dispatch #(.BD_NUM(BD_NUM), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .free_bd(free_bd), .bd_re(bd_re), .bd_dat(bd_dat),
    .a_cmp(a_cmp), .xfer_start(xfer_start), .xfer_sys_addr(xfer_sys_addr),
    .xfer_blk_addr(xfer_blk_addr), .xfer_done(xfer_done), .xfer_err(xfer_err),
    .busy(busy), .err_flag(err_flag), .done_cnt(done_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // BD store model: registered word read, free-slot counter reacting to a_cmp.
  logic [AW-1:0]   mem [0:15];
  int              rd_ptr;
  bit              set_free = 1'b0;
  bit              auto_inc = 1'b1;
  logic [BD_W-1:0] set_val  = BD_W'(BD_NUM);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 0;
      bd_dat <= '0;
    end else if (bd_re) begin
      bd_dat <= mem[rd_ptr];
      rd_ptr <= (rd_ptr + 1) % 16;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) free_bd <= BD_W'(BD_NUM);
    else if (set_free) free_bd <= set_val;
    else if (a_cmp && auto_inc) free_bd <= free_bd + BD_W'(1);
  end

  // Scoreboard of expected launch addresses, popped on every xfer_start.
  typedef struct {
    logic [31:0] sys;
    logic [31:0] blk;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int re_cnt = 0, acmp_cnt = 0, start_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (bd_re) re_cnt++;
    if (a_cmp) acmp_cnt++;
    if (xfer_start) begin
      start_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_start", 32'(xfer_start), 32'd0);
      end else begin
        e = sb.pop_front();
        $display("launch sys=0x%08h blk=0x%08h", xfer_sys_addr, xfer_blk_addr);
        chk("sys_addr", xfer_sys_addr, e.sys);
        chk("blk_addr", xfer_blk_addr, e.blk);
      end
    end
  end

  typedef struct {
    logic [31:0] sys;
    logic [31:0] blk;
    int          delay;
    bit          err;
    bit          collide;
    int          exp_starts;
    int          exp_acmp;
    bit          exp_err;
    logic [15:0] exp_cnt;
  } vec_t;
  vec_t vt[4];

  task automatic wait_start();
    for (int i = 0; i < 20 && !xfer_start; i++) @(negedge clk);
    chk("start_seen", 32'(xfer_start), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("back_to_idle", 32'(busy), 32'd0);
  endtask

  task automatic pulse_done(input int delay, input bit err);
    repeat (delay) @(negedge clk);
    xfer_done = 1'b1;
    xfer_err  = err;
    @(negedge clk);
    xfer_done = 1'b0;
    xfer_err  = 1'b0;
  endtask

  task automatic run_bd(input vec_t v);
    int s0, a0, r0, t0;
    exp_t e;
    mem[rd_ptr] = v.sys;
    mem[(rd_ptr + 1) % 16] = v.blk;
    e.sys = v.sys;
    e.blk = v.blk;
    for (int k = 0; k < v.exp_starts; k++) sb.push_back(e);
    s0 = start_cnt; a0 = acmp_cnt; r0 = re_cnt;
    @(negedge clk);
    set_val = 3; set_free = 1'b1; auto_inc = 1'b1; en = 1'b1;
    @(negedge clk);
    set_free = 1'b0;
    for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
    chk("left_idle", 32'(busy), 32'd1);
    t0 = cyc;
    wait_start();
    chk("start_latency", 32'(cyc - t0), 32'd3);
    for (int k = 0; k < v.exp_starts; k++) begin
      if (k > 0) wait_start();
      pulse_done(v.delay, v.err && (k == 0));
    end
    chk("reads_per_bd", 32'(re_cnt - r0), 32'd2);
    chk("sys_stable", xfer_sys_addr, v.sys);
    chk("blk_stable", xfer_blk_addr, v.blk);
    for (int i = 0; i < 10 && !a_cmp; i++) @(negedge clk);
    chk("cmpl_seen", 32'(a_cmp), 32'd1);
    if (v.collide) begin
      set_val = 2; set_free = 1'b1; auto_inc = 1'b0;
      @(negedge clk);
      set_free = 1'b0; auto_inc = 1'b1; en = 1'b0;
    end
    wait_idle();
    @(negedge clk);
    chk("idle_stays", 32'(busy), 32'd0);
    chk("done_cnt", 32'(done_cnt), 32'(v.exp_cnt));
    chk("err_flag", 32'(err_flag), 32'(v.exp_err));
    chk("a_cmp_pulses", 32'(acmp_cnt - a0), 32'(v.exp_acmp));
    chk("start_pulses", 32'(start_cnt - s0), 32'(v.exp_starts));
    $display("bd sys=0x%08h blk=0x%08h done_cnt=%0d err_flag=%0d a_cmp=%0d",
             v.sys, v.blk, done_cnt, err_flag, acmp_cnt - a0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, a0;
    logic [15:0] c0;
    exp_t e;

    vt[0] = '{32'h0000_1000, 32'h0000_0020, 10, 1'b0, 1'b0, 1, 1, 1'b0, 16'd1};
    vt[1] = '{32'h0000_2000, 32'h0000_0040, 3,  1'b0, 1'b1, 1, 2, 1'b0, 16'd2};
    vt[2] = '{32'h0000_3000, 32'h0000_0060, 1,  1'b0, 1'b0, 1, 1, 1'b0, 16'd3};
`ifdef SD_BD_DISPATCH_RETRY_EN
    vt[3] = '{32'h0000_4000, 32'h0000_0080, 4,  1'b1, 1'b0, 2, 1, 1'b0, 16'd4};
`else
    vt[3] = '{32'h0000_4000, 32'h0000_0080, 4,  1'b1, 1'b0, 1, 1, 1'b1, 16'd4};
`endif
    for (int i = 0; i < 16; i++) mem[i] = '0;

    rst = 1'b1; en = 1'b0; xfer_done = 1'b0; xfer_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bd_re", 32'(bd_re), 32'd0);
    chk("rst_a_cmp", 32'(a_cmp), 32'd0);
    chk("rst_xfer_start", 32'(xfer_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_sys_addr", xfer_sys_addr, 32'd0);
    chk("rst_blk_addr", xfer_blk_addr, 32'd0);
    rst = 1'b0;
    en  = 1'b1;

    // Nothing pending with en=1, and a stray erroring xfer_done in IDLE.
    repeat (3) @(negedge clk);
    chk("idle_no_pending", 32'(busy), 32'd0);
    pulse_done(0, 1'b1);
    @(negedge clk);
    chk("idle_done_ignored_err", 32'(err_flag), 32'd0);
    chk("idle_done_ignored_cnt", 32'(done_cnt), 32'd0);

    for (int i = 0; i < 4; i++) run_bd(vt[i]);

    // en dropped mid-transfer with two BDs pending.
    mem[rd_ptr] = 32'h0000_5000; mem[(rd_ptr + 1) % 16] = 32'h0000_00A0;
    mem[(rd_ptr + 2) % 16] = 32'h0000_6000; mem[(rd_ptr + 3) % 16] = 32'h0000_00C0;
    e.sys = 32'h0000_5000; e.blk = 32'h0000_00A0; sb.push_back(e);
    e.sys = 32'h0000_6000; e.blk = 32'h0000_00C0; sb.push_back(e);
    s0 = start_cnt; c0 = done_cnt;
    set_val = 2; set_free = 1'b1; en = 1'b1;
    @(negedge clk);
    set_free = 1'b0;
    wait_start();
    @(negedge clk);
    en = 1'b0;
    pulse_done(2, 1'b0);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("en_low_idle", 32'(busy), 32'd0);
    chk("en_low_one_start", 32'(start_cnt - s0), 32'd1);
    chk("en_low_done_cnt", 32'(done_cnt), 32'(c0 + 16'd1));
    en = 1'b1;
    wait_start();
    pulse_done(5, 1'b0);
    wait_idle();
    @(negedge clk);
    chk("en_high_done_cnt", 32'(done_cnt), 32'(c0 + 16'd2));
    chk("en_high_free_bd", 32'(free_bd), 32'(BD_NUM));
    $display("en toggle: starts=%0d done_cnt=%0d", start_cnt - s0, done_cnt);

    // Reset while waiting on a transfer.
    mem[rd_ptr] = 32'h0000_7000; mem[(rd_ptr + 1) % 16] = 32'h0000_00E0;
    e.sys = 32'h0000_7000; e.blk = 32'h0000_00E0; sb.push_back(e);
    set_val = 3; set_free = 1'b1;
    @(negedge clk);
    set_free = 1'b0;
    wait_start();
    @(negedge clk);
    a0 = acmp_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("wrst_bd_re", 32'(bd_re), 32'd0);
    chk("wrst_a_cmp", 32'(a_cmp), 32'd0);
    chk("wrst_xfer_start", 32'(xfer_start), 32'd0);
    chk("wrst_busy", 32'(busy), 32'd0);
    chk("wrst_err_flag", 32'(err_flag), 32'd0);
    chk("wrst_done_cnt", 32'(done_cnt), 32'd0);
    chk("wrst_sys_addr", xfer_sys_addr, 32'd0);
    chk("wrst_blk_addr", xfer_blk_addr, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulse_done(2, 1'b0);
    repeat (5) @(negedge clk);
    chk("wrst_no_a_cmp", 32'(acmp_cnt - a0), 32'd0);
    chk("wrst_stays_idle", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("reset in WAIT: busy=%0d done_cnt=%0d", busy, done_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
